pc_strobe_sequencer: RTL and testbench

Registered control-strobe generator for the 16-bit program counter, built from two cascaded 8-bit counter-with-input-register devices. It accepts single-cycle clear / increment / load requests from instruction decode. It converts each request into a glitch-free, correctly ordered sequence of counter-side strobes, driven into the counters' CCK, CCKEN, CCLR_bar, RCK, RCKEN_bar, CLOAD_bar and inQ pins. It reports progress through a Busy/Done handshake.

---
 rtl/pc_strobe_sequencer_if.sv | 51 +++++
 rtl/pc_strobe_sequencer.sv | 149 ++++++++++++++
 tb/tb_pc_strobe_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_strobe_sequencer_if.sv
// pc_strobe_sequencer_if: request/handshake and counter-strobe bundle
// between instruction decode, the sequencer and the PC counter devices.
interface pc_strobe_sequencer_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  Req_clr;
    logic                  Req_load;
    logic                  Req_inc;
    logic [ADDR_WIDTH-1:0] Load_addr;
    logic                  Busy;
    logic                  Done;
    logic [ADDR_WIDTH-1:0] PC_data;
    logic                  CCK;
    logic                  CCKEN;
    logic                  CCLR_bar;
    logic                  RCK;
    logic                  RCKEN_bar;
    logic                  CLOAD_bar;

    modport master (
        output Req_clr,
        output Req_load,
        output Req_inc,
        output Load_addr,
        input  Busy,
        input  Done,
        input  PC_data,
        input  CCK,
        input  CCKEN,
        input  CCLR_bar,
        input  RCK,
        input  RCKEN_bar,
        input  CLOAD_bar
    );

    modport slave (
        input  Req_clr,
        input  Req_load,
        input  Req_inc,
        input  Load_addr,
        output Busy,
        output Done,
        output PC_data,
        output CCK,
        output CCKEN,
        output CCLR_bar,
        output RCK,
        output RCKEN_bar,
        output CLOAD_bar
    );
endinterface

// File: rtl/pc_strobe_sequencer.sv
// pc_strobe_sequencer: turns clear/increment/load requests into ordered,
// flop-driven strobes for two cascaded 8-bit counter/register devices.
module pc_strobe_sequencer #(
    parameter int ADDR_WIDTH = 16,
    parameter int HOLD       = 1
) (
    input  logic                 Clk,
    input  logic                 Clear_bar,
    pc_strobe_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE,
        CLR_SETUP,
        CLR_CLK,
        INC_SETUP,
        INC_CLK,
        LD_SETUP,
        LD_RCK,
        LD_CLOW,
        DONE
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

    state_t                state;
    logic [3:0]            hold_cnt;
    logic [ADDR_WIDTH-1:0] pc_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  cck_q;
    logic                  ccken_q;
    logic                  cclr_bar_q;
    logic                  rck_q;
    logic                  rcken_bar_q;
    logic                  cload_bar_q;
    logic                  take_clr;
    logic                  take_load;
    logic                  take_inc;

    // Fixed-priority decode made one-hot so the IDLE dispatch stays unique
    always_comb begin
        take_clr  = bus.Req_clr;
        take_load = !bus.Req_clr && bus.Req_load;
        take_inc  = !bus.Req_clr && !bus.Req_load && bus.Req_inc;
    end

    // Sequencer: every strobe is a flop, defaulting to inactive each cycle
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            pc_data_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cck_q       <= 1'b0;
            ccken_q     <= 1'b0;
            cclr_bar_q  <= 1'b1;
            rck_q       <= 1'b0;
            rcken_bar_q <= 1'b1;
            cload_bar_q <= 1'b1;
        end else begin
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            cck_q       <= 1'b0;
            ccken_q     <= 1'b0;
            cclr_bar_q  <= 1'b1;
            rck_q       <= 1'b0;
            rcken_bar_q <= 1'b1;
            cload_bar_q <= 1'b1;
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        take_clr: begin
                            state      <= CLR_SETUP;
                            cclr_bar_q <= 1'b0;
                        end
                        take_load: begin
                            state       <= LD_SETUP;
                            pc_data_q   <= bus.Load_addr;
                            rcken_bar_q <= 1'b0;
                        end
                        take_inc: begin
                            state   <= INC_SETUP;
                            ccken_q <= 1'b1;
                        end
                        default: begin
                            busy_q <= 1'b0;
                        end
                    endcase
                end
                CLR_SETUP: begin
                    state      <= CLR_CLK;
                    cclr_bar_q <= 1'b0;
                    cck_q      <= 1'b1;
                end
                CLR_CLK: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                INC_SETUP: begin
                    state   <= INC_CLK;
                    ccken_q <= 1'b1;
                    cck_q   <= 1'b1;
                end
                INC_CLK: begin
                    state  <= DONE;
                    done_q <= 1'b1;
                end
                LD_SETUP: begin
                    state       <= LD_RCK;
                    rcken_bar_q <= 1'b0;
                    rck_q       <= 1'b1;
                end
                LD_RCK: begin
                    state       <= LD_CLOW;
                    cload_bar_q <= 1'b0;
                    hold_cnt    <= HOLD_LAST;
                end
                LD_CLOW: begin
                    if (hold_cnt == 4'd0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        hold_cnt    <= hold_cnt - 4'd1;
                        cload_bar_q <= 1'b0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.PC_data   = pc_data_q;
    assign bus.CCK       = cck_q;
    assign bus.CCKEN     = ccken_q;
    assign bus.CCLR_bar  = cclr_bar_q;
    assign bus.RCK       = rck_q;
    assign bus.RCKEN_bar = rcken_bar_q;
    assign bus.CLOAD_bar = cload_bar_q;
endmodule

// File: tb/tb_pc_strobe_sequencer.sv
// tb_pc_strobe_sequencer: two sequencers (HOLD 1 and 3) driving modelled
// 8-bit counter/register pairs, checked against a request-schedule model.
module tb_pc_strobe_sequencer;
    logic        Clk = 1'b0;
    logic        Clear_bar = 1'b1;
    logic        chk_en = 1'b0;
    logic        req_clr = 1'b0;
    logic        req_load = 1'b0;
    logic        req_inc = 1'b0;
    logic [15:0] load_addr = '0;
    int          tests = 0;
    int          fails = 0;

    logic [1:0]       busy_v;
    logic [1:0]       done_v;
    logic [1:0]       cload_v;
    logic [1:0][15:0] pc_v;
    logic [1:0][15:0] reg_v;

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int H = (g == 0) ? 1 : 3;
        localparam int LD_LEN = 3 + H;

        pc_strobe_sequencer_if #(.ADDR_WIDTH(16)) ifc ();

        assign ifc.Req_clr   = req_clr;
        assign ifc.Req_load  = req_load;
        assign ifc.Req_inc   = req_inc;
        assign ifc.Load_addr = load_addr;

        pc_strobe_sequencer #(.ADDR_WIDTH(16), .HOLD(H)) dut (
            .Clk       (Clk),
            .Clear_bar (Clear_bar),
            .bus       (ifc)
        );

        logic [7:0] c_lo = '0;
        logic [7:0] c_hi = '0;
        logic [7:0] r_lo = '0;
        logic [7:0] r_hi = '0;

        // Counter pair; high half counts on low-half terminal count,
        // and the shared system reset blocks a parallel load
        always @(posedge ifc.CCK or posedge ifc.CLOAD_bar) begin
            if (ifc.CCK) begin
                if (!ifc.CCLR_bar) begin
                    c_lo <= '0;
                    c_hi <= '0;
                end else if (ifc.CCKEN) begin
                    c_lo <= c_lo + 8'd1;
                    if (c_lo == 8'hFF) c_hi <= c_hi + 8'd1;
                end
            end else if (Clear_bar) begin
                c_lo <= r_lo;
                c_hi <= r_hi;
            end
        end

        // Input registers of both devices
        always @(posedge ifc.RCK) begin
            if (!ifc.RCKEN_bar) {r_hi, r_lo} <= ifc.PC_data;
        end

        assign busy_v[g]  = ifc.Busy;
        assign done_v[g]  = ifc.Done;
        assign cload_v[g] = ifc.CLOAD_bar;
        assign pc_v[g]    = {c_hi, c_lo};
        assign reg_v[g]   = {r_hi, r_lo};

        int          op = 0;
        int          k = -1;
        int          last;
        logic [15:0] r_data = '0;
        logic [15:0] r_pc = '0;
        logic [15:0] r_reg = '0;
        logic [7:0]  ev;

        // Expected strobes from operation kind and cycles since acceptance
        always_comb begin
            last  = (op == 3) ? LD_LEN - 1 : 2;
            ev[7] = k >= 0;
            ev[6] = k >= 0 && k == last;
            ev[5] = op != 3 && k == 1;
            ev[4] = op == 2 && k >= 0 && k <= 1;
            ev[3] = !(op == 1 && k >= 0 && k <= 1);
            ev[2] = op == 3 && k == 1;
            ev[1] = !(op == 3 && k >= 0 && k <= 1);
            ev[0] = !(op == 3 && k >= 2 && k <= 1 + H);
        end

        // Request schedule: op 1 clear, 2 increment, 3 load
        always @(posedge Clk or negedge Clear_bar) begin
            if (!Clear_bar) begin
                op     <= 0;
                k      <= -1;
                r_data <= '0;
            end else if (k < 0) begin
                if (req_clr) begin
                    op <= 1;
                    k  <= 0;
                end else if (req_load) begin
                    op     <= 3;
                    k      <= 0;
                    r_data <= load_addr;
                end else if (req_inc) begin
                    op <= 2;
                    k  <= 0;
                end
            end else if (k == last) begin
                k <= -1;
            end else begin
                k <= k + 1;
                if (k == 0 && op == 1) r_pc <= '0;
                if (k == 0 && op == 2) r_pc <= r_pc + 16'd1;
                if (k == 0 && op == 3) r_reg <= r_data;
                if (k == last - 1 && op == 3) r_pc <= r_reg;
            end
        end

        // Per-cycle comparison away from the active edge
        always @(negedge Clk) begin
            if (chk_en) begin
                chk($sformatf("strobes%0d", g),
                    32'({ifc.Busy, ifc.Done, ifc.CCK, ifc.CCKEN,
                         ifc.CCLR_bar, ifc.RCK, ifc.RCKEN_bar,
                         ifc.CLOAD_bar}), 32'(ev));
                chk($sformatf("pc_data%0d", g), 32'(ifc.PC_data),
                    32'(r_data));
                chk($sformatf("pc%0d", g), 32'({c_hi, c_lo}), 32'(r_pc));
                chk($sformatf("inreg%0d", g), 32'({r_hi, r_lo}),
                    32'(r_reg));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((busy_v != 2'b00) && n < 40) begin
            @(negedge Clk);
            n++;
        end
        chk("wait_idle", 32'(n < 40), 32'd1);
    endtask

    task automatic issue(input logic c, input logic l, input logic i,
                         input logic [15:0] a);
        @(negedge Clk);
        req_clr   = c;
        req_load  = l;
        req_inc   = i;
        load_addr = a;
        @(negedge Clk);
        req_clr  = 1'b0;
        req_load = 1'b0;
        req_inc  = 1'b0;
        wait_idle();
    endtask

    task automatic chk_pc(input string tag, input logic [15:0] exp);
        chk({tag, "_0"}, 32'(pc_v[0]), 32'(exp));
        chk({tag, "_1"}, 32'(pc_v[1]), 32'(exp));
    endtask

    initial begin
        int d0;
        int d1;
        #1;
        Clear_bar = 1'b0;
        chk_en    = 1'b1;
        repeat (4) begin
            @(negedge Clk);
            {req_clr, req_load, req_inc} = 3'($urandom);
            load_addr = 16'($urandom);
        end
        chk("rst_busy", 32'(busy_v), 32'd0);
        chk("rst_cload", 32'(cload_v), 32'd3);
        @(negedge Clk);
        req_clr  = 1'b0;
        req_load = 1'b0;
        req_inc  = 1'b0;
        #2 Clear_bar = 1'b1;

        issue(1'b0, 1'b1, 1'b0, 16'h00FF);
        chk_pc("ld_00ff", 16'h00FF);
        issue(1'b0, 1'b0, 1'b1, 16'h0000);
        chk_pc("inc_carry", 16'h0100);
        issue(1'b0, 1'b1, 1'b0, 16'h1234);
        chk_pc("ld_1234", 16'h1234);

        issue(1'b0, 1'b1, 1'b0, 16'h5555);
        issue(1'b1, 1'b1, 1'b1, 16'h9999);
        chk_pc("prio_clr", 16'h0000);
        issue(1'b0, 1'b1, 1'b1, 16'h2468);
        chk_pc("prio_ld", 16'h2468);

        @(negedge Clk);
        load_addr = 16'hABCD;
        req_load  = 1'b1;
        @(negedge Clk);
        req_load = 1'b0;
        @(negedge Clk);
        req_inc = 1'b1;
        @(negedge Clk);
        req_inc = 1'b0;
        d0 = 0;
        d1 = 0;
        repeat (12) begin
            @(negedge Clk);
            d0 += int'(done_v[0]);
            d1 += int'(done_v[1]);
        end
        chk("drop_done0", 32'(d0), 32'd1);
        chk("drop_done1", 32'(d1), 32'd1);
        chk_pc("drop_pc", 16'hABCD);
        issue(1'b0, 1'b1, 1'b0, 16'h2468);

        @(negedge Clk);
        load_addr = 16'h7777;
        req_load  = 1'b1;
        @(negedge Clk);
        req_load = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("mid_clow", 32'(cload_v), 32'd0);
        #2 Clear_bar = 1'b0;
        #1;
        chk("mid_cload", 32'(cload_v), 32'd3);
        chk("mid_busy", 32'(busy_v), 32'd0);
        chk_pc("mid_pc", 16'h2468);
        chk("mid_reg0", 32'(reg_v[0]), 32'h7777);
        chk("mid_reg1", 32'(reg_v[1]), 32'h7777);
        @(negedge Clk);
        #2 Clear_bar = 1'b1;
        wait_idle();

        repeat (400) begin
            @(negedge Clk);
            req_clr   = ($urandom_range(0, 9) == 0);
            req_load  = ($urandom_range(0, 3) == 0);
            req_inc   = ($urandom_range(0, 2) == 0);
            load_addr = 16'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 Clear_bar = 1'b0;
                @(negedge Clk);
                #2 Clear_bar = 1'b1;
            end
        end
        @(negedge Clk);
        req_clr  = 1'b0;
        req_load = 1'b0;
        req_inc  = 1'b0;
        wait_idle();
        @(negedge Clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end
endmodule
